// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle 16-bit core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB/BRANCH and decodes datapath controls from the current state.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+1 when memory completes
// DECODE | precompute branch target into ALUOut, dispatch on opcode, finish JMP/illegal
// EXEC   | R-type/ADDI compute, or LW/SW address generation
// MEM    | data read/write at ALUOut, held until mem_ready
// WB     | register file write from ALUOut or MDR
// BRANCH | compare rs/rt, conditionally load PC from ALUOut
// HALT   | memory timeout; frozen with bus_err until reset
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       illegal_op,
  output logic       bus_err,
  output logic       retired,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             bus_err_q, bus_err_nxt;

  logic op_lw, op_sw, op_rtype, op_addi, op_beq, op_bne, op_jmp, op_illegal;
  logic timeout_hit;

  assign op_lw      = (opcode == 4'b0000);
  assign op_sw      = (opcode == 4'b0001);
  assign op_addi    = (opcode == 4'b0011);
  assign op_rtype   = opcode inside {4'b0010, 4'b0100, 4'b0101, 4'b0110,
                                     4'b0111, 4'b1000, 4'b1001};
  assign op_beq     = (opcode == 4'b1010);
  assign op_bne     = (opcode == 4'b1011);
  assign op_jmp     = (opcode == 4'b1100);
  assign op_illegal = (opcode >= 4'b1101);

  // Counter sitting at TIMEOUT means the allowed waits are used up; ready can still win this cycle.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      bus_err_q <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    bus_err_nxt  = bus_err_q;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    ir_we        = 1'b0;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    illegal_op   = 1'b0;
    retired      = 1'b0;

    case (state)
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b01;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = DECODE;
        end else if (timeout_hit) begin
          bus_err_nxt = 1'b1;
          state_nxt   = HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 2'b01;
        if (op_lw || op_sw || op_rtype || op_addi) begin
          state_nxt = EXEC;
        end else if (op_beq || op_bne) begin
          state_nxt = BRANCH;
        end else if (op_jmp) begin
          pc_we     = 1'b1;
          pc_src    = 2'b10;
          retired   = 1'b1;
          state_nxt = FETCH;
        end else begin
          illegal_op = op_illegal;
          state_nxt  = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        if (op_lw || op_sw) begin
          alu_src_b = 2'b10;
          alu_op    = 2'b01;
          state_nxt = MEM;
        end else begin
          alu_src_b = op_addi ? 2'b10 : 2'b00;
          alu_op    = 2'b00;
          state_nxt = WB;
        end
      end
      MEM: begin
        iord   = 1'b1;
        mem_rd = op_lw;
        mem_wr = op_sw;
        if (mem_ready) begin
          if (op_lw) begin
            state_nxt = WB;
          end else begin
            retired   = 1'b1;
            state_nxt = FETCH;
          end
        end else if (timeout_hit) begin
          bus_err_nxt = 1'b1;
          state_nxt   = HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      WB: begin
        reg_we    = 1'b1;
        wb_sel    = op_lw;
        retired   = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        pc_src    = 2'b01;
        pc_we     = op_beq ? alu_zero : ~alu_zero;
        retired   = 1'b1;
        state_nxt = FETCH;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase

    // Reset dominates combinationally so nothing is written in the cycle rst is seen.
    if (rst) begin
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      ir_we      = 1'b0;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_we     = 1'b0;
      wb_sel     = 1'b0;
      illegal_op = 1'b0;
      retired    = 1'b0;
    end
  end

  assign bus_err = bus_err_q & ~rst;
  assign state_o = rst ? 3'd0 : state;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main sequencer for the multi-cycle 16-bit core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH and drives the datapath mux selects, write enables and the 2-bit ALUop.
- ALUop feeds the ALU control decoder: 00 = funct by opcode, 01 = add, 10 = subtract for compare.
- Handles variable-latency memory via mem_ready, flags illegal opcodes, and halts on a memory timeout.

Parameters:
- TIMEOUT, 16: max consecutive wait cycles in FETCH or MEM before a bus error; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous active-high reset.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_we  out  1  PC write enable.
- pc_src  out  2  PC input select: 00 ALU result, 01 ALUOut register, 10 jump target.
- ir_we  out  1  instruction register load.
- iord  out  1  address select: 0 PC, 1 ALUOut.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B select: 00 rt, 01 const 1, 10 sign-ext imm, 11 sign-ext branch offset.
- alu_op  out  2  ALUop to the ALU control decoder.
- reg_we  out  1  register file write enable.
- wb_sel  out  1  writeback data select: 0 ALUOut, 1 MDR.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  sticky; memory timeout occurred.
- retired  out  1  one-cycle pulse in the final cycle of each completed instruction.
- state_o  out  3  current state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, BRANCH 5, HALT 6.

Behaviour:
- Opcode map:
  - 0000 LW, 0001 SW.
  - R-type ALU ops: 0010 ADD, 0100 SUB, 0101 NOT, 0110 SHL, 0111 SHR, 1000 AND, 1001 OR.
  - 0011 ADDI.
  - 1010 BEQ, 1011 BNE, 1100 JMP.
  - 1101-1111 illegal.
- Reset: while rst=1, all outputs are 0, state<=FETCH, wait counter<=0, bus_err<=0. The first FETCH cycle is the first cycle after rst deasserts.
- Outputs are decoded from the current state, plus opcode/alu_zero/mem_ready where stated. Any output not listed for a state is 0.
- FETCH:
  - Drives mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=01.
  - If mem_ready=1: ir_we=1, pc_we=1, pc_src=00, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=01, which precomputes the branch target into ALUOut.
  - Next state: LW/SW/R-type/ADDI go to EXEC; BEQ/BNE go to BRANCH.
  - JMP: pc_we=1, pc_src=10, retired=1, go to FETCH.
  - Illegal opcode: illegal_op=1, no writes, no retired, go to FETCH.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op=00, go to WB.
  - ADDI: alu_src_a=1, alu_src_b=10, alu_op=00, go to WB.
  - LW/SW: alu_src_a=1, alu_src_b=10, alu_op=01, go to MEM.
- MEM:
  - Drives iord=1, plus mem_rd=1 for LW or mem_wr=1 for SW. Strobes stay asserted until mem_ready.
  - On mem_ready: LW goes to WB; SW asserts retired=1 and goes to FETCH.
  - Otherwise stay in MEM and increment the wait counter.
- WB: reg_we=1, wb_sel=1 for LW and 0 otherwise, retired=1, go to FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=10, pc_src=01.
  - pc_we=alu_zero for BEQ, pc_we=~alu_zero for BNE.
  - retired=1, go to FETCH.
- Wait counter:
  - Cleared on every state transition and whenever mem_ready=1.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT while still waiting: in the next cycle bus_err<=1 and state<=HALT.
  - Aborted instructions perform no writes and assert no retired.
  - mem_ready arriving in the same cycle the counter hits TIMEOUT wins: the access completes and no error is raised.
- HALT: all outputs 0 except bus_err=1; only rst exits.
- Cycle counts with mem_ready always 1: R-type/ADDI 4, LW 5, SW 4, BEQ/BNE 3, JMP 2, illegal 2. Each memory wait cycle adds 1.
- rst asserted in any state, including HALT or mid-wait, aborts on the next edge with no partial writes after that edge.

Test Plan:
- ADD (0010), mem_ready=1 -> state_o 0,1,2,4; alu_op 01,01,00,00; reg_we=1 and retired=1 only in cycle 4.
- LW with mem_ready low for 3 cycles in MEM -> mem_rd=1 and iord=1 held for 4 MEM cycles; then WB with wb_sel=1, reg_we=1; 8 cycles total.
- BEQ with alu_zero=1 -> in BRANCH: pc_we=1, pc_src=01, alu_op=10. BNE with alu_zero=1 -> pc_we=0, retired=1.
- Opcode 1110 -> illegal_op=1 for one DECODE cycle, no pc_we/reg_we/mem_wr, back to FETCH, retired=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> HALT (state_o=6) with bus_err=1 after the 4th wait cycle; stays there despite later mem_ready=1; rst returns state_o=0 and bus_err=0.
- rst pulsed during SW in MEM -> mem_wr=0 from the next cycle onward, no retired pulse, FETCH on the first post-reset cycle.
